// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue feeding decode over valid/ready.
// Redirects flush the queue and restart fetch at the supplied PC.
module fetch_queue_unit #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 8,
    parameter int DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   redirect_valid,
    input  logic [WIDTH-1:0]       redirect_pc,
    input  logic                   hold,
    output logic [ADDR_BITS-1:0]   imem_addr,
    input  logic [WIDTH-1:0]       imem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_inst,
    output logic [WIDTH-1:0]       out_pc_next,
    output logic [$clog2(DEPTH):0] out_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             push;

    assign pc_plus1  = fetch_pc + WIDTH'(1);
    assign imem_addr = fetch_pc[ADDR_BITS-1:0];
    assign full      = (count == CW'(DEPTH));

    // A redirect cycle hides the head so nothing is consumed while the queue is being flushed.
    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect_valid & ~hold & (~full | pop);

    assign out_inst    = inst_mem[rd_ptr];
    assign out_pc_next = pc_mem[rd_ptr];
    assign out_count   = count;

    // Storage is cleared on reset so the head outputs read zero until the first fetch lands.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= imem_data;
                pc_mem[wr_ptr]   <= pc_plus1;
                wr_ptr           <= wr_ptr + PW'(1);
                fetch_pc         <= pc_plus1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: free-run, fill/drain, redirect, hold, index wrap and reset.
// Instruction memory returns 0x100 + index for every address.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        clear;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc_next;
    logic [2:0]  out_count;

    int checks = 0;
    int errors = 0;

    fetch_queue_unit #(
        .WIDTH(32), .ADDR_BITS(8), .DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .clear(clear),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .hold(hold), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc_next(out_pc_next), .out_count(out_count)
    );

    always #5 clk = ~clk;

    assign imem_data = 32'h100 + {24'b0, imem_addr};

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then land just after it so new inputs settle before checks.
    task automatic next_step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [31:0] inst, input logic [31:0] pcn, input logic [2:0] cnt);
        check_output({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_output({tag, "_inst"}, out_inst, inst);
        check_output({tag, "_pcnext"}, out_pc_next, pcn);
        check_output({tag, "_count"}, {29'b0, out_count}, {29'b0, cnt});
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check_output({tag, "_inst"}, out_inst, 32'd0);
        check_output({tag, "_pcnext"}, out_pc_next, 32'd0);
        check_output({tag, "_count"}, {29'b0, out_count}, 32'd0);
    endtask

    initial begin
        clear          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hold           = 1'b0;
        out_ready      = 1'b1;
        #1;
        check_zero("reset");
        check_output("reset_addr", {24'b0, imem_addr}, 32'd0);
        #7 clear = 1'b1;

        // Free-run: one instruction per cycle, occupancy stays at one
        for (int k = 1; k <= 5; k++) begin
            next_step();
            #1;
            check_head($sformatf("run%0d", k), 32'h100 + k - 1, k, 3'd1);
        end

        // Reset mid-stream, then fill with decode stalled
        clear = 1'b0;
        #1;
        check_zero("midreset");
        clear     = 1'b1;
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_step();
            #1;
            check_output($sformatf("fill_count%0d", k), {29'b0, out_count}, (k < 4) ? k : 4);
        end
        check_output("fill_addr", {24'b0, imem_addr}, 32'd4);
        check_output("fill_head", out_inst, 32'h100);

        // Drain with simultaneous push on a full queue: no gaps, count pinned at 4
        out_ready = 1'b1;
        #1;
        check_head("drain0", 32'h100, 32'd1, 3'd4);
        for (int k = 1; k <= 7; k++) begin
            next_step();
            #1;
            check_head($sformatf("drain%0d", k), 32'h100 + k, k + 1, 3'd4);
        end

        // One held pop leaves three entries, then redirect to 0x20
        hold = 1'b1;
        next_step();
        hold           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        #1;
        check_output("redir_count_before", {29'b0, out_count}, 32'd3);
        check_output("redir_valid_same", {31'b0, out_valid}, 32'd0);
        next_step();
        redirect_valid = 1'b0;
        #1;
        check_output("redir_count_after", {29'b0, out_count}, 32'd0);
        check_output("redir_valid_after", {31'b0, out_valid}, 32'd0);
        check_output("redir_addr", {24'b0, imem_addr}, 32'h20);
        next_step();
        #1;
        check_head("redir_head", 32'h120, 32'h21, 3'd1);
        next_step();
        #1;
        check_head("redir_next", 32'h121, 32'h22, 3'd1);

        // Hold three cycles: queue drains, PC frozen, fetch resumes at same address
        hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            next_step();
            if (k == 3) hold = 1'b0;
            #1;
            check_output($sformatf("hold_count%0d", k), {29'b0, out_count}, 32'd0);
            check_output($sformatf("hold_addr%0d", k), {24'b0, imem_addr}, 32'h22);
        end
        next_step();
        #1;
        check_head("hold_resume", 32'h122, 32'h23, 3'd1);

        // Redirect while held still loads the PC; then fetch wraps the index
        hold           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFF;
        next_step();
        hold           = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check_output("holdredir_addr", {24'b0, imem_addr}, 32'hFF);
        check_output("holdredir_count", {29'b0, out_count}, 32'd0);
        next_step();
        #1;
        check_head("wrap_ff", 32'h1FF, 32'h100, 3'd1);
        check_output("wrap_addr", {24'b0, imem_addr}, 32'h00);
        next_step();
        #1;
        check_head("wrap_00", 32'h100, 32'h101, 3'd1);

        // Asynchronous reset with entries pending clears outputs at once
        out_ready = 1'b0;
        next_step();
        clear = 1'b0;
        #1;
        check_zero("final_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
